// File: rtl/i2c_responder_pkg.sv
// Shared types and constants for the I2C codec responder.
package i2c_responder_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_REG_ADDR,
      ST_REG_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [6:0] DEF_DEVICE_ADDR = 7'b0011010;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with a history stage for edge and
// START/STOP detection.
module i2c_bus_sync
   import i2c_responder_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_sync_q, scl_sync_d;
   logic [1:0] sda_sync_q, sda_sync_d;
   logic       scl_hist_q, scl_hist_d;
   logic       sda_hist_q, sda_hist_d;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_i};
      sda_sync_d = {sda_sync_q[0], sda_i};
      scl_hist_d = scl_sync_q[1];
      sda_hist_d = sda_sync_q[1];
   end

   // Reset to the idle bus level so no false edge appears after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
      end
   end

   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_sync_q[1] & ~scl_hist_q;
   assign scl_fall  = ~scl_sync_q[1] & scl_hist_q;
   assign start_det = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
   assign stop_det  = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target with a pointer-addressed register file, standing in
// for the SSM2603 codec.
module i2c_codec_responder
   import i2c_responder_pkg::*;
#(
   parameter logic [6:0]  DEVICE_ADDR = DEF_DEVICE_ADDR,
   parameter int unsigned NUM_REGS    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       reg_wr_strobe,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data,
   output logic       busy
);

   localparam int unsigned IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0]  NREG = 9'(NUM_REGS);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic       busy_q, busy_d;
   logic       wr_stb_q, wr_stb_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] regs_q [NUM_REGS];

   logic       ptr_ok;
   logic [7:0] ptr_data;
   logic [7:0] rx_byte;
   logic       byte_done;

   assign ptr_ok    = {1'b0, ptr_q} < NREG;
   assign ptr_data  = ptr_ok ? regs_q[ptr_q[IW-1:0]] : 8'h00;
   assign dbg_data  = ({1'b0, dbg_addr} < NREG) ? regs_q[dbg_addr[IW-1:0]] : 8'h00;
   assign rx_byte   = {sh_q[6:0], sda_s};
   assign byte_done = scl_rise && (cnt_q == 3'd7);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (stop_det) begin
         state_d  = ST_IDLE;
         cnt_d    = 3'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d  = ST_DEV_ADDR;
         cnt_d    = 3'd0;
         sda_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_IGNORE: ;
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 3'd1;
               end
               if (byte_done) begin
                  if (state_q == ST_DEV_ADDR) begin
                     if (rx_byte[7:1] == DEVICE_ADDR) begin
                        state_d = ST_DEV_ACK;
                        busy_d  = 1'b1;
                        rw_d    = rx_byte[0];
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end else if (state_q == ST_REG_ADDR) begin
                     ptr_d   = rx_byte;
                     state_d = ST_REG_ACK;
                  end else begin
                     wr_stb_d  = ptr_ok;
                     wr_addr_d = ptr_ok ? ptr_q : wr_addr_q;
                     wr_data_d = ptr_ok ? rx_byte : wr_data_q;
                     ptr_d     = ptr_q + 8'd1;
                     state_d   = ST_WR_ACK;
                  end
               end
            end
            // First fall drives the ACK, second fall ends the ACK bit.
            ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = ~I2C_ACK;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 3'd0;
                     state_d  = ST_WR_DATA;
                     if (state_q == ST_DEV_ACK) begin
                        if (rw_q) begin
                           state_d  = ST_RD_DATA;
                           sh_d     = ptr_data;
                           sda_oe_d = ~ptr_data[7];
                        end else begin
                           state_d  = ST_REG_ADDR;
                        end
                     end
                  end
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     cnt_d    = cnt_q + 3'd1;
                     sh_d     = {sh_q[6:0], 1'b0};
                     sda_oe_d = ~sh_q[6];
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s == I2C_NACK) state_d = ST_IGNORE;
                  else ptr_d = ptr_q + 8'd1;
               end else if (scl_fall) begin
                  sh_d     = ptr_data;
                  sda_oe_d = ~ptr_data[7];
                  cnt_d    = 3'd0;
                  state_d  = ST_RD_DATA;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         sh_q      <= 8'h00;
         ptr_q     <= 8'h00;
         rw_q      <= 1'b0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         ptr_q     <= ptr_d;
         rw_q      <= rw_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
      end else if (wr_stb_d) begin
         regs_q[wr_addr_d[IW-1:0]] <= wr_data_d;
      end
   end

   assign sda_oe        = sda_oe_q;
   assign busy          = busy_q;
   assign reg_wr_strobe = wr_stb_q;
   assign reg_wr_addr   = wr_addr_q;
   assign reg_wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bit-banged I2C master against a byte-level register model; write
// strobes are checked by a separate monitor from an expectation queue.
module tb_i2c_codec_responder;

   localparam int         Q     = 6;
   localparam int         NREGS = 16;
   localparam logic [6:0] DEV   = 7'h1A;

   logic       clk = 1'b0;
   logic       reset;
   logic       m_scl, m_sda;
   logic       sda_bus;
   logic       sda_oe, reg_wr_strobe, busy;
   logic [7:0] reg_wr_addr, reg_wr_data, dbg_addr, dbg_data;

   assign sda_bus = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_codec_responder dut (
      .clk           (clk),
      .reset         (reset),
      .scl_i         (m_scl),
      .sda_i         (sda_bus),
      .sda_oe        (sda_oe),
      .reg_wr_strobe (reg_wr_strobe),
      .reg_wr_addr   (reg_wr_addr),
      .reg_wr_data   (reg_wr_data),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data),
      .busy          (busy)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  mregs [256];
   logic [7:0]  mptr;
   logic [15:0] exp_q [$];
   logic [7:0]  txb [$];
   logic [15:0] mon_e;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reg_wr_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL strobe_unexpected: got addr 0x%0h data 0x%0h expected none",
                     reg_wr_addr, reg_wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("strobe_addr", reg_wr_addr, mon_e[15:8]);
            chk("strobe_data", reg_wr_data, mon_e[7:0]);
         end
      end
   end

   task automatic wq(input int n = Q);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b0; wq();
      m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wq();
      m_sda = 1'b0; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b1; wq(2 * Q);
   endtask

   task automatic i2c_bit(input logic b, output logic r);
      wq();
      m_sda = b; wq();
      m_scl = 1'b1; wq();
      r = sda_bus; wq();
      m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
      i2c_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] v);
      logic r;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         i2c_bit(1'b1, r);
         v = {v[6:0], r};
      end
      i2c_bit(mack ? 1'b0 : 1'b1, r);
   endtask

   function automatic logic [7:0] model_rd(input logic [7:0] a);
      return (int'(a) < NREGS) ? mregs[a] : 8'h00;
   endfunction

   task automatic write_txn(input logic [6:0] dev, input logic [7:0] ra);
      logic a;
      logic m;
      m = (dev == DEV);
      i2c_start();
      send_byte({dev, 1'b0}, a);
      chk("wr_dev_ack", a, m ? 1'b0 : 1'b1);
      send_byte(ra, a);
      chk("wr_reg_ack", a, m ? 1'b0 : 1'b1);
      if (m) mptr = ra;
      foreach (txb[k]) begin
         if (m) begin
            if (int'(mptr) < NREGS) begin
               mregs[mptr] = txb[k];
               exp_q.push_back({mptr, txb[k]});
            end
            mptr = mptr + 8'd1;
         end
         send_byte(txb[k], a);
         chk("wr_data_ack", a, m ? 1'b0 : 1'b1);
      end
      i2c_stop();
   endtask

   task automatic read_txn(input logic [7:0] ra, input int n);
      logic       a;
      logic [7:0] v;
      i2c_start();
      send_byte({DEV, 1'b0}, a);
      chk("rd_dev_ack", a, 1'b0);
      send_byte(ra, a);
      chk("rd_reg_ack", a, 1'b0);
      mptr = ra;
      i2c_start();
      send_byte({DEV, 1'b1}, a);
      chk("rd_dev2_ack", a, 1'b0);
      chk("busy_during", busy, 1'b1);
      for (int k = 0; k < n; k++) begin
         recv_byte(k < n - 1, v);
         chk("rd_data", v, model_rd(mptr));
         if (k < n - 1) mptr = mptr + 8'd1;
      end
      chk("rd_release", sda_oe, 1'b0);
      i2c_stop();
      chk("busy_after_stop", busy, 1'b0);
   endtask

   task automatic dbg_sweep();
      for (int i = 0; i < NREGS + 2; i++) begin
         dbg_addr = 8'(i);
         #1;
         chk("dbg_data", dbg_data, model_rd(8'(i)));
      end
   endtask

   initial begin
      logic       a;
      logic       r;
      logic [7:0] ra;
      int         n;

      for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
      mptr     = 8'h00;
      reset    = 1'b1;
      m_scl    = 1'b1;
      m_sda    = 1'b1;
      dbg_addr = 8'h00;
      wq(4);
      chk("rst_sda_oe", sda_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_strobe", reg_wr_strobe, 1'b0);
      chk("rst_wr_addr", reg_wr_addr, 8'h00);
      chk("rst_wr_data", reg_wr_data, 8'h00);
      dbg_sweep();
      reset = 1'b0;
      wq(4);

      txb = '{8'h07};
      write_txn(DEV, 8'h04);
      dbg_sweep();
      read_txn(8'h04, 1);

      txb = '{8'h55};
      write_txn(7'h1B, 8'h04);
      dbg_sweep();

      txb = '{8'hA1, 8'hA2, 8'hA3};
      write_txn(DEV, 8'h0E);
      txb = '{8'h11, 8'h22};
      write_txn(DEV, 8'h0E);
      read_txn(8'h0E, 3);

      // STOP in the middle of a data byte
      i2c_start();
      send_byte({DEV, 1'b0}, a);
      chk("part_dev_ack", a, 1'b0);
      send_byte(8'h05, a);
      chk("part_reg_ack", a, 1'b0);
      mptr = 8'h05;
      for (int i = 0; i < 4; i++) i2c_bit(1'b1, r);
      i2c_stop();
      chk("part_busy", busy, 1'b0);
      chk("part_sda_oe", sda_oe, 1'b0);
      read_txn(8'h05, 1);

      for (int t = 0; t < 16; t++) begin
         ra = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
         n  = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 0) begin
            txb = {};
            for (int k = 0; k < n; k++) txb.push_back(8'($urandom));
            write_txn(($urandom_range(0, 5) == 0) ? 7'h2C : DEV, ra);
         end else begin
            read_txn(ra, n);
         end
      end
      dbg_sweep();

      // Reset while the responder pulls SDA for a 0 read bit
      txb = '{8'h07};
      write_txn(DEV, 8'h04);
      i2c_start();
      send_byte({DEV, 1'b0}, a);
      send_byte(8'h04, a);
      i2c_start();
      send_byte({DEV, 1'b1}, a);
      chk("rst_rd_ack", a, 1'b0);
      wq();
      chk("rst_rd_bit7", sda_oe, 1'b1);
      reset = 1'b1;
      #1;
      chk("rst_async_release", sda_oe, 1'b0);
      for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
      mptr  = 8'h00;
      wq();
      m_sda = 1'b1;
      m_scl = 1'b1;
      wq();
      reset = 1'b0;
      wq();
      chk("rst_busy2", busy, 1'b0);
      dbg_sweep();

      txb = '{8'h3C};
      write_txn(DEV, 8'h02);
      read_txn(8'h02, 1);

      wq(10);
      chk("strobe_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
